// File: rtl/hub75_fb_loader.sv
// Write-side sequencer for the HUB75 frame buffer: turns a raster pixel
// stream into line-buffer writes, row commits and per-frame buffer swaps.
module hub75_fb_loader #(
  parameter int N_BANKS     = 2,
  parameter int N_ROWS      = 32,
  parameter int N_COLS      = 64,
  parameter int BITDEPTH    = 24,
  parameter int LOG_N_BANKS = (N_BANKS > 1) ? $clog2(N_BANKS) : 1,
  parameter int LOG_N_ROWS  = (N_ROWS  > 1) ? $clog2(N_ROWS)  : 1,
  parameter int LOG_N_COLS  = (N_COLS  > 1) ? $clog2(N_COLS)  : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BITDEPTH-1:0]    in_data,
  input  logic                   in_sof,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [LOG_N_BANKS-1:0] wr_bank_addr,
  output logic [LOG_N_ROWS-1:0]  wr_row_addr,
  output logic                   wr_row_store,
  input  logic                   wr_row_rdy,
  output logic                   wr_row_swap,
  output logic [BITDEPTH-1:0]    wr_data,
  output logic [LOG_N_COLS-1:0]  wr_col_addr,
  output logic                   wr_en,
  input  logic                   frame_sync,
  output logic                   frame_swap,
  output logic                   frame_done
);

  localparam logic [LOG_N_COLS-1:0]  COL_LAST  = LOG_N_COLS'(N_COLS - 1);
  localparam logic [LOG_N_ROWS-1:0]  ROW_LAST  = LOG_N_ROWS'(N_ROWS - 1);
  localparam logic [LOG_N_BANKS-1:0] BANK_LAST = LOG_N_BANKS'(N_BANKS - 1);

  typedef enum logic [1:0] {
    FILL       = 2'd0,
    ROW_DONE   = 2'd1,
    FRAME_WAIT = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [LOG_N_COLS-1:0]    col_q;
  logic [LOG_N_ROWS-1:0]    row_q;
  logic [LOG_N_BANKS-1:0]   bank_q;
  logic [LOG_N_ROWS-1:0]    row_hold_q;
  logic [LOG_N_BANKS-1:0]   bank_hold_q;
  logic                     busy_q;
  logic                     armed_q;

  logic beat;
  logic resync;
  logic store_done;
  logic no_flight;
  logic last_row;
  logic store_fire;
  logic swap_fire;

  // The store engine's rdy is only trusted from the second cycle after a
  // store pulse, so a stale rdy left over from before the pulse is ignored.
  assign store_done = busy_q & armed_q & wr_row_rdy;
  assign no_flight  = ~busy_q | store_done;

  assign in_ready = (state_q == FILL) & ~rst;
  assign beat     = in_valid & in_ready;
  assign resync   = beat & in_sof & ((col_q != '0) | (row_q != '0) | (bank_q != '0));
  assign last_row = (row_q == ROW_LAST) & (bank_q == BANK_LAST);

  assign wr_en       = beat;
  assign wr_data     = rst ? '0 : in_data;
  assign wr_col_addr = resync ? '0 : col_q;

  assign wr_row_store = store_fire;
  assign wr_row_swap  = store_fire;
  assign wr_bank_addr = store_fire ? bank_q : bank_hold_q;
  assign wr_row_addr  = store_fire ? row_q  : row_hold_q;

  assign frame_swap = swap_fire;
  assign frame_done = swap_fire;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  // Next-state logic and the store/swap pulses.
  always_comb begin
    state_d    = state_q;
    store_fire = 1'b0;
    swap_fire  = 1'b0;
    case (state_q)
      FILL: begin
        if (beat && !resync && (col_q == COL_LAST)) state_d = ROW_DONE;
      end
      ROW_DONE: begin
        if (no_flight && wr_row_rdy) begin
          store_fire = 1'b1;
          state_d    = last_row ? FRAME_WAIT : FILL;
        end
      end
      FRAME_WAIT: begin
        if (no_flight && frame_sync) begin
          swap_fire = 1'b1;
          state_d   = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Raster position: column advances per beat, row/bank per committed row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      bank_q <= '0;
    end else begin
      if (beat) begin
        if (resync) begin
          col_q  <= LOG_N_COLS'(1);
          row_q  <= '0;
          bank_q <= '0;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
      if (store_fire) begin
        row_q <= row_q + 1'b1;
        if (row_q == ROW_LAST) bank_q <= bank_q + 1'b1;
      end
      if (swap_fire) begin
        col_q  <= '0;
        row_q  <= '0;
        bank_q <= '0;
      end
    end
  end

  // Hold the address of the most recently stored row between store pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_hold_q  <= '0;
      bank_hold_q <= '0;
    end else if (store_fire) begin
      row_hold_q  <= row_q;
      bank_hold_q <= bank_q;
    end
  end

  // Track the outstanding store until the engine reports idle again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= 1'b0;
      armed_q <= 1'b0;
    end else if (store_fire) begin
      busy_q  <= 1'b1;
      armed_q <= 1'b0;
    end else if (store_done) begin
      busy_q  <= 1'b0;
      armed_q <= 1'b0;
    end else if (busy_q) begin
      armed_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hub75_fb_loader.sv
// Self-checking bench for hub75_fb_loader with a pixel-count based model.
module tb_hub75_fb_loader;

  localparam int NB = 2;
  localparam int NR = 4;
  localparam int NC = 8;
  localparam int BD = 24;
  localparam int TOTAL_ROWS = NB * NR;

  logic          clk = 1'b0;
  logic          rst;
  logic [BD-1:0] in_data;
  logic          in_sof;
  logic          in_valid;
  logic          in_ready;
  logic [0:0]    wr_bank_addr;
  logic [1:0]    wr_row_addr;
  logic          wr_row_store;
  logic          wr_row_rdy;
  logic          wr_row_swap;
  logic [BD-1:0] wr_data;
  logic [2:0]    wr_col_addr;
  logic          wr_en;
  logic          frame_sync;
  logic          frame_swap;
  logic          frame_done;

  hub75_fb_loader #(.N_BANKS(NB), .N_ROWS(NR), .N_COLS(NC), .BITDEPTH(BD)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sof(in_sof), .in_valid(in_valid),
    .in_ready(in_ready), .wr_bank_addr(wr_bank_addr), .wr_row_addr(wr_row_addr),
    .wr_row_store(wr_row_store), .wr_row_rdy(wr_row_rdy), .wr_row_swap(wr_row_swap),
    .wr_data(wr_data), .wr_col_addr(wr_col_addr), .wr_en(wr_en),
    .frame_sync(frame_sync), .frame_swap(frame_swap), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  int store_count = 0;
  int swap_count = 0;
  int last_swap_cyc = -1;
  int last_sync_cyc = -1;
  int store_log[$];

  int src_idx = 0;
  int exp_idx = 0;

  int  rand_mode = 0;
  bit  stale_mode = 1'b0;
  int  hold_at = -1;
  int  hold_len = 0;
  int  sync_period = 0;
  int  sync_req = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic noteTimeout(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: timed out waiting (cycle %0d)", name, cyc);
  endtask

  // Pixel source: sends n pixels whose data is a running pixel index.
  task automatic applyStimulus(input int n, input int sof_at, input int gap_pct, input int sof_pct);
    for (int k = 0; k < n; k++) begin
      int  waited;
      bit  accepted;
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = src_idx[BD-1:0];
      in_sof   = (k == sof_at) || (sof_pct > 0 && $urandom_range(99) < sof_pct);
      waited   = 0;
      accepted = 1'b0;
      while (!accepted) begin
        @(negedge clk);
        accepted = in_ready && !rst;
        @(posedge clk); #1;
        waited++;
        if (!accepted && waited > 2000) begin
          noteTimeout("pixel_accept");
          in_valid = 1'b0;
          in_sof   = 1'b0;
          return;
        end
      end
      src_idx++;
      in_valid = 1'b0;
      in_sof   = 1'b0;
    end
  endtask

  task automatic waitStores(input int target, input int budget);
    int n = 0;
    while (store_count < target) begin
      @(posedge clk); #1;
      n++;
      if (n > budget) begin
        noteTimeout("row_store");
        return;
      end
    end
  endtask

  task automatic waitSwaps(input int target, input int budget);
    int n = 0;
    while (swap_count < target) begin
      @(posedge clk); #1;
      n++;
      if (n > budget) begin
        noteTimeout("frame_swap");
        return;
      end
    end
  endtask

  task automatic doReset();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic checkStoreOrder(input int base, input int first_row, input int n);
    checkOutput("store_total", store_log.size() - base, n);
    for (int i = 0; i < n && base + i < store_log.size(); i++)
      checkOutput("store_order", store_log[base + i], (first_row + i) % TOTAL_ROWS);
  endtask

  // Store engine model: rdy goes low for a while after each store pulse.
  initial begin
    int rdy_seen = 0;
    int lowcnt = 0;
    bit skip = 1'b0;
    wr_row_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (store_count != rdy_seen) begin
        rdy_seen = store_count;
        if (store_count == hold_at) lowcnt = hold_len;
        else if (rand_mode != 0)    lowcnt = $urandom_range(6);
        else                        lowcnt = 5;
        skip = (rand_mode != 0) ? ($urandom_range(1) == 1) : stale_mode;
      end
      if (skip) begin
        skip = 1'b0;
        wr_row_rdy = 1'b1;
      end else if (lowcnt > 0) begin
        wr_row_rdy = 1'b0;
        lowcnt--;
      end else begin
        wr_row_rdy = (rand_mode != 0) ? ($urandom_range(3) != 0) : 1'b1;
      end
    end
  end

  // Scan-side frame_sync: periodic pulses plus on-demand single pulses.
  initial begin
    int sync_done = 0;
    int sync_cnt = 0;
    frame_sync = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (sync_req != sync_done) begin
        frame_sync = 1'b1;
        sync_done = sync_req;
      end else if (sync_period > 0) begin
        sync_cnt++;
        if (sync_cnt >= sync_period) begin
          sync_cnt = 0;
          frame_sync = 1'b1;
        end else begin
          frame_sync = 1'b0;
        end
      end else begin
        frame_sync = 1'b0;
      end
    end
  end

  // Reference model in terms of pixels accepted and rows committed this frame.
  initial begin
    int  m_p = 0, m_stored = 0, m_sp = 0, m_bank = 0, m_row = 0;
    bit  m_busy = 1'b0;
    bit  done_now, free_now, exp_ready, exp_wen, resync, exp_store, exp_swap;
    int  exp_col;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_wr_en", wr_en, 0);
        checkOutput("rst_wr_row_store", wr_row_store, 0);
        checkOutput("rst_wr_row_swap", wr_row_swap, 0);
        checkOutput("rst_frame_swap", frame_swap, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        checkOutput("rst_addr", {wr_bank_addr, wr_row_addr, wr_col_addr}, 0);
        checkOutput("rst_wr_data", wr_data, 0);
        m_p = 0; m_stored = 0; m_busy = 1'b0; m_bank = 0; m_row = 0;
      end else begin
        done_now  = m_busy && (cyc - m_sp >= 2) && wr_row_rdy;
        free_now  = !m_busy || done_now;
        exp_ready = ((m_p / NC) == m_stored) && (m_stored < TOTAL_ROWS);
        exp_wen   = in_valid && exp_ready;
        resync    = exp_wen && in_sof && (m_p != 0);
        exp_col   = resync ? 0 : (m_p % NC);
        exp_store = ((m_p / NC) > m_stored) && free_now && wr_row_rdy;
        exp_swap  = (m_stored == TOTAL_ROWS) && free_now && frame_sync;
        if (exp_store) begin
          m_bank = m_stored / NR;
          m_row  = m_stored % NR;
        end
        checkOutput("in_ready", in_ready, exp_ready);
        checkOutput("wr_en", wr_en, exp_wen);
        if (exp_wen) begin
          checkOutput("wr_col_addr", wr_col_addr, exp_col);
          checkOutput("wr_data", wr_data, exp_idx[BD-1:0]);
        end
        checkOutput("wr_row_store", wr_row_store, exp_store);
        checkOutput("wr_row_swap", wr_row_swap, exp_store);
        checkOutput("wr_bank_addr", wr_bank_addr, m_bank);
        checkOutput("wr_row_addr", wr_row_addr, m_row);
        checkOutput("frame_swap", frame_swap, exp_swap);
        checkOutput("frame_done", frame_done, exp_swap);

        if (wr_row_store) begin
          store_count++;
          store_log.push_back(int'(wr_bank_addr) * NR + int'(wr_row_addr));
        end
        if (frame_swap) begin
          swap_count++;
          last_swap_cyc = cyc;
        end
        if (frame_sync) last_sync_cyc = cyc;

        if (exp_wen) begin
          exp_idx++;
          if (resync) begin
            m_p = 1;
            m_stored = 0;
          end else begin
            m_p++;
          end
        end
        if (exp_store) begin
          m_stored++;
          m_busy = 1'b1;
          m_sp = cyc;
        end else if (done_now) begin
          m_busy = 1'b0;
        end
        if (exp_swap) begin
          m_p = 0;
          m_stored = 0;
        end
      end
    end
  end

  // Scenario sequencer.
  initial begin
    int st0, sw0, src0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_sof = 1'b0;
    in_data = '0;
    doReset();

    $display("[TB] one frame, continuous pixels, periodic frame_sync");
    sync_period = 200;
    st0 = store_log.size(); sw0 = swap_count;
    applyStimulus(64, -1, 0, 0);
    waitSwaps(sw0 + 1, 600);
    checkStoreOrder(st0, 0, 8);
    checkOutput("one_swap", swap_count - sw0, 1);
    checkOutput("swap_on_sync", last_swap_cyc, last_sync_cyc);

    $display("[TB] store engine busy for 40 cycles after the first store");
    doReset();
    st0 = store_log.size(); sw0 = swap_count; src0 = src_idx;
    hold_at = store_count + 1;
    hold_len = 40;
    fork
      applyStimulus(64, -1, 0, 0);
      begin
        waitStores(hold_at, 300);
        repeat (30) @(posedge clk);
        #1;
        checkOutput("hold_pixels", src_idx - src0, 16);
        checkOutput("hold_in_ready", in_ready, 0);
      end
    join
    waitSwaps(sw0 + 1, 600);
    checkStoreOrder(st0, 0, 8);
    hold_at = -1;

    $display("[TB] stale rdy after store, frame_sync during last store");
    for (int pass = 0; pass < 2; pass++) begin
      doReset();
      sync_period = 0;
      stale_mode = (pass == 0);
      st0 = store_log.size(); sw0 = swap_count;
      applyStimulus(64, -1, 0, 0);
      waitStores(store_count + (8 - (store_log.size() - st0)), 300);
      sync_req++;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("early_sync_ignored", swap_count - sw0, 0);
      repeat (27) @(posedge clk);
      #1;
      sync_req++;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("late_sync_swap", swap_count - sw0, 1);
      checkOutput("late_swap_on_sync", last_swap_cyc, last_sync_cyc);
      checkStoreOrder(st0, 0, 8);
    end
    stale_mode = 1'b0;

    $display("[TB] sof on pixel 11 resynchronises the frame");
    doReset();
    sync_period = 200;
    st0 = store_log.size(); sw0 = swap_count;
    applyStimulus(11, -1, 0, 0);
    applyStimulus(64, 0, 0, 0);
    waitSwaps(sw0 + 1, 600);
    checkOutput("sof_first_store", store_log.size() > st0 ? store_log[st0] : -1, 0);
    checkStoreOrder(st0 + 1, 0, 8);

    $display("[TB] reset after 20 pixels");
    doReset();
    applyStimulus(20, -1, 0, 0);
    #1 rst = 1'b1;
    #1;
    checkOutput("imm_in_ready", in_ready, 0);
    checkOutput("imm_wr_en", wr_en, 0);
    checkOutput("imm_store", {wr_row_store, wr_row_swap}, 0);
    checkOutput("imm_swap", {frame_swap, frame_done}, 0);
    checkOutput("imm_addr", {wr_bank_addr, wr_row_addr, wr_col_addr}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    st0 = store_log.size(); sw0 = swap_count;
    applyStimulus(64, -1, 0, 0);
    waitSwaps(sw0 + 1, 600);
    checkStoreOrder(st0, 0, 8);

    $display("[TB] randomized traffic");
    doReset();
    rand_mode = 1;
    sync_period = 37;
    applyStimulus(300, -1, 30, 2);
    repeat (100) @(posedge clk);
    rand_mode = 0;
    sync_period = 0;
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
